// File: rtl/shevm_pad_ctrl_if.sv
// rtl/shevm_pad_ctrl_if.sv - pad-ring and core signal bundle for shevm_pad_ctrl
// master drives the raw pads and core requests, slave is the pad controller.
interface shevm_pad_ctrl_if #(
  parameter int GPIO_W = 16
);
  logic              pgood_i;
  logic [GPIO_W-1:0] bm_gpio_i;
  logic              pca_en_i;
  logic              timi_en_i;
  logic              led_clr_i;
  logic              nand_wp_o;
  logic              nor_wp_n_o;
  logic              eeprom_wp_o;
  logic              pca9306_en_o;
  logic              dsp_timi0_o;
  logic [GPIO_W-1:0] gpio_db_o;
  logic [GPIO_W-1:0] gpio_chg_o;
  logic              pwr_on_o;
  logic [3:0]        debug_led_o;

  modport master (
    output pgood_i, bm_gpio_i, pca_en_i, timi_en_i, led_clr_i,
    input  nand_wp_o, nor_wp_n_o, eeprom_wp_o, pca9306_en_o, dsp_timi0_o,
    input  gpio_db_o, gpio_chg_o, pwr_on_o, debug_led_o
  );

  modport slave (
    input  pgood_i, bm_gpio_i, pca_en_i, timi_en_i, led_clr_i,
    output nand_wp_o, nor_wp_n_o, eeprom_wp_o, pca9306_en_o, dsp_timi0_o,
    output gpio_db_o, gpio_chg_o, pwr_on_o, debug_led_o
  );
endinterface

// File: rtl/shevm_pad_ctrl.sv
// rtl/shevm_pad_ctrl.sv - C6678 EVM pad sequencer, GPIO debounce, TIMI0 and debug LEDs
// Pads stay protected until power-good has been stable for PG_RELEASE_CYC cycles.
module shevm_pad_ctrl #(
  parameter int GPIO_W         = 16,
  parameter int DEB_CYC        = 48000,
  parameter int PG_RELEASE_CYC = 4800,
  parameter int TIMI_DIV       = 48,
  parameter int HB_CYC         = 24000000
) (
  input logic             main_48mhz_clk_r_i,
  input logic             rst_i,
  shevm_pad_ctrl_if.slave pad
);
  localparam int WW = $clog2(PG_RELEASE_CYC + 1);
  localparam int TW = $clog2(TIMI_DIV);
  localparam int DW = $clog2(DEB_CYC + 1);
  localparam int HW = $clog2(HB_CYC + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(PG_RELEASE_CYC - 1);
  localparam logic [TW-1:0] TIMI_LAST = TW'(TIMI_DIV - 1);
  localparam logic [TW-1:0] TIMI_HALF = TW'(TIMI_DIV / 2);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);
  localparam logic [HW-1:0] HB_LAST   = HW'(HB_CYC - 1);

  typedef enum logic [1:0] {ST_OFF, ST_WAIT, ST_ON} state_t;

  state_t            state_q, state_d;
  logic [WW-1:0]     wait_cnt_q, wait_cnt_d;
  logic              pg_m_q, pg_m_d, pg_s_q, pg_s_d;
  logic [GPIO_W-1:0] gp_m_q, gp_m_d, gp_s_q, gp_s_d;
  logic              wp_q, wp_d, pca_q, pca_d, timi_q, timi_d, pwr_on_q, pwr_on_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [GPIO_W-1:0] gpio_db_q, gpio_db_d, gpio_chg_q, gpio_chg_d;
  logic [DW-1:0]     db_cnt_q [GPIO_W];
  logic [DW-1:0]     db_cnt_d [GPIO_W];
  logic [HW-1:0]     hb_cnt_q, hb_cnt_d;
  logic              hb_q, hb_d, led_chg_q, led_chg_d, led_flt_q, led_flt_d;
  logic              fault_evt, on_d, run;

  always_comb begin
    pg_m_d     = pad.pgood_i;
    pg_s_d     = pg_m_q;
    gp_m_d     = pad.bm_gpio_i;
    gp_s_d     = gp_m_q;
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    fault_evt  = 1'b0;
    unique case (state_q)
      ST_OFF: if (pg_s_q) begin
        state_d    = ST_WAIT;
        wait_cnt_d = '0;
      end
      ST_WAIT: begin
        // Losing power-good beats reaching the terminal count.
        if (!pg_s_q)                      state_d = ST_OFF;
        else if (wait_cnt_q == WAIT_LAST) state_d = ST_ON;
        else                              wait_cnt_d = wait_cnt_q + WW'(1);
      end
      ST_ON: if (!pg_s_q) begin
        state_d   = ST_OFF;
        fault_evt = 1'b1;
      end
      default: state_d = ST_OFF;
    endcase

    // Pads register from the next state so a power-good loss reaches them in 3 cycles.
    on_d     = (state_d == ST_ON);
    wp_d     = on_d;
    pca_d    = on_d & pad.pca_en_i;
    pwr_on_d = on_d;
    run      = (state_q == ST_ON) && pad.timi_en_i;
    tcnt_d   = (!run || tcnt_q == TIMI_LAST) ? '0 : tcnt_q + TW'(1);
    timi_d   = run && on_d && (tcnt_q < TIMI_HALF);

    gpio_db_d  = gpio_db_q;
    gpio_chg_d = '0;
    db_cnt_d   = db_cnt_q;
    for (int i = 0; i < GPIO_W; i++) begin
      if (gp_s_q[i] == gpio_db_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DEB_LAST) begin
        gpio_db_d[i]  = gp_s_q[i];
        gpio_chg_d[i] = 1'b1;
        db_cnt_d[i]   = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DW'(1);
      end
    end

    hb_cnt_d  = (hb_cnt_q == HB_LAST) ? '0 : hb_cnt_q + HW'(1);
    hb_d      = (hb_cnt_q == HB_LAST) ? ~hb_q : hb_q;
    // Set events outrank a simultaneous clear.
    led_chg_d = (|gpio_chg_q) | (led_chg_q & ~pad.led_clr_i);
    led_flt_d = fault_evt | (led_flt_q & ~pad.led_clr_i);
  end

  always_ff @(posedge main_48mhz_clk_r_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_OFF;
      wait_cnt_q <= '0;
      pg_m_q     <= 1'b0;
      pg_s_q     <= 1'b0;
      gp_m_q     <= '0;
      gp_s_q     <= '0;
      wp_q       <= 1'b0;
      pca_q      <= 1'b0;
      timi_q     <= 1'b0;
      pwr_on_q   <= 1'b0;
      tcnt_q     <= '0;
      gpio_db_q  <= '0;
      gpio_chg_q <= '0;
      db_cnt_q   <= '{default: '0};
      hb_cnt_q   <= '0;
      hb_q       <= 1'b0;
      led_chg_q  <= 1'b0;
      led_flt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      pg_m_q     <= pg_m_d;
      pg_s_q     <= pg_s_d;
      gp_m_q     <= gp_m_d;
      gp_s_q     <= gp_s_d;
      wp_q       <= wp_d;
      pca_q      <= pca_d;
      timi_q     <= timi_d;
      pwr_on_q   <= pwr_on_d;
      tcnt_q     <= tcnt_d;
      gpio_db_q  <= gpio_db_d;
      gpio_chg_q <= gpio_chg_d;
      db_cnt_q   <= db_cnt_d;
      hb_cnt_q   <= hb_cnt_d;
      hb_q       <= hb_d;
      led_chg_q  <= led_chg_d;
      led_flt_q  <= led_flt_d;
    end
  end

  assign pad.nand_wp_o    = wp_q;
  assign pad.nor_wp_n_o   = wp_q;
  assign pad.eeprom_wp_o  = wp_q;
  assign pad.pca9306_en_o = pca_q;
  assign pad.dsp_timi0_o  = timi_q;
  assign pad.gpio_db_o    = gpio_db_q;
  assign pad.gpio_chg_o   = gpio_chg_q;
  assign pad.pwr_on_o     = pwr_on_q;
  assign pad.debug_led_o  = {led_flt_q, led_chg_q, pwr_on_q, hb_q};
endmodule

// File: tb/tb_shevm_pad_ctrl.sv
// tb/tb_shevm_pad_ctrl.sv - directed self-checking bench for shevm_pad_ctrl
// Cycle k means the state sampled 1 ns after the k-th rising edge following a stimulus change.
module tb_shevm_pad_ctrl;
  localparam int GPIO_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic [GPIO_W-1:0] seen;

  shevm_pad_ctrl_if #(.GPIO_W(GPIO_W)) pad ();

  shevm_pad_ctrl #(
    .GPIO_W(GPIO_W), .DEB_CYC(4), .PG_RELEASE_CYC(10), .TIMI_DIV(6), .HB_CYC(8)
  ) dut (
    .main_48mhz_clk_r_i(clk),
    .rst_i(rst),
    .pad(pad)
  );

  always #5 clk = ~clk;

  wire [2:0] wp = {pad.nand_wp_o, pad.nor_wp_n_o, pad.eeprom_wp_o};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wp"}, wp, 0);
    check({tag, "_pca"}, pad.pca9306_en_o, 0);
    check({tag, "_timi"}, pad.dsp_timi0_o, 0);
    check({tag, "_db"}, pad.gpio_db_o, 0);
    check({tag, "_chg"}, pad.gpio_chg_o, 0);
    check({tag, "_pwr"}, pad.pwr_on_o, 0);
    check({tag, "_led"}, pad.debug_led_o, 0);
  endtask

  task automatic power_up(input string tag);
    for (int k = 1; k <= 13; k++) begin
      step(1);
      if (k == 7)  check({tag, "_hb_lo"}, pad.debug_led_o[0], 0);
      if (k == 8)  check({tag, "_hb_hi"}, pad.debug_led_o[0], 1);
      if (k == 11) check({tag, "_wp_c11"}, wp, 0);
      if (k == 12) check({tag, "_wp_c12"}, wp, 0);
    end
    check({tag, "_wp_c13"}, wp, 3'b111);
    check({tag, "_pwr_c13"}, pad.pwr_on_o, 1);
    check({tag, "_led1"}, pad.debug_led_o[1], 1);
  endtask

  initial begin
    pad.pgood_i   = 1'b0;
    pad.bm_gpio_i = '0;
    pad.pca_en_i  = 1'b0;
    pad.timi_en_i = 1'b0;
    pad.led_clr_i = 1'b0;
    step(3);
    check_all_zero("reset");

    rst = 1'b0;
    pad.pgood_i = 1'b1;
    power_up("pwrup");
    check("pwrup_timi_idle", pad.dsp_timi0_o, 0);

    pad.pca_en_i = 1'b1;
    step(1);
    check("pca_on", pad.pca9306_en_o, 1);
    pad.pca_en_i = 1'b0;
    step(1);
    check("pca_off", pad.pca9306_en_o, 0);

    pad.timi_en_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1);
      check($sformatf("timi_c%0d", i), pad.dsp_timi0_o, ((i % 6) < 3) ? 1 : 0);
    end
    step(1);
    check("timi_pre_fall", pad.dsp_timi0_o, 1);
    pad.pgood_i = 1'b0;
    step(3);
    check("fall_timi", pad.dsp_timi0_o, 0);
    check("fall_wp", wp, 0);
    check("fall_pwr", pad.pwr_on_o, 0);
    check("fall_led3", pad.debug_led_o[3], 1);
    pad.timi_en_i = 1'b0;
    pad.led_clr_i = 1'b1;
    step(1);
    pad.led_clr_i = 1'b0;
    check("clr_led3", pad.debug_led_o[3], 0);

    pad.pgood_i = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      step(1);
      if (k == 5) pad.pgood_i = 1'b0;
      if (k == 6) pad.pgood_i = 1'b1;
      if (k == 13) check("wglitch_wp_c13", wp, 0);
      if (k == 18) check("wglitch_wp_c18", wp, 0);
    end
    check("wglitch_wp_c19", wp, 3'b111);
    check("wglitch_led3", pad.debug_led_o[3], 0);

    pad.pgood_i = 1'b0;
    step(1);
    pad.pgood_i = 1'b1;
    step(2);
    check("onglitch_wp", wp, 0);
    check("onglitch_led3", pad.debug_led_o[3], 1);
    pad.led_clr_i = 1'b1;
    step(1);
    pad.led_clr_i = 1'b0;
    check("onglitch_clr", pad.debug_led_o[3], 0);

    pad.bm_gpio_i[5] = 1'b1;
    step(3);
    pad.bm_gpio_i[5] = 1'b0;
    seen = '0;
    for (int k = 0; k < 8; k++) begin
      step(1);
      seen |= pad.gpio_chg_o;
    end
    check("short_chg", seen, 0);
    check("short_db", pad.gpio_db_o, 0);

    pad.bm_gpio_i[5] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step(1);
      if (k == 5) check("held_db_c5", pad.gpio_db_o, 0);
      if (k == 5) check("held_chg_c5", pad.gpio_chg_o, 0);
      if (k == 6) check("held_db_c6", pad.gpio_db_o, 16'h0020);
      if (k == 6) check("held_chg_c6", pad.gpio_chg_o, 16'h0020);
    end
    check("held_chg_c7", pad.gpio_chg_o, 0);
    check("held_led2", pad.debug_led_o[2], 1);

    pad.led_clr_i = 1'b1;
    step(1);
    pad.led_clr_i = 1'b0;
    check("clr_led2", pad.debug_led_o[2], 0);
    pad.bm_gpio_i[5] = 1'b0;
    step(6);
    check("simul_chg", pad.gpio_chg_o, 16'h0020);
    check("simul_db", pad.gpio_db_o, 0);
    pad.led_clr_i = 1'b1;
    step(1);
    pad.led_clr_i = 1'b0;
    check("simul_led2", pad.debug_led_o[2], 1);

    step(2);
    check("pre_rst_pwr", pad.pwr_on_o, 1);
    pad.pca_en_i  = 1'b1;
    pad.timi_en_i = 1'b1;
    step(2);
    check("pre_rst_timi", pad.dsp_timi0_o, 1);
    check("pre_rst_pca", pad.pca9306_en_o, 1);
    check("pre_rst_led21", pad.debug_led_o[2:1], 2'b11);
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    pad.pca_en_i  = 1'b0;
    pad.timi_en_i = 1'b0;
    step(2);
    rst = 1'b0;
    power_up("repwr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
